// File: rtl/riscv_uop_pkg.sv
// Shared micro-op definitions for the DHRUT-V retire path: the buffered
// write-back entry format and the arbitration mode encodings.
package riscv_uop_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // One completed result waiting to be written back.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_chan_fifo.sv
// Per-channel result FIFO. The head entry is presented combinationally so the
// arbiter can load it into the write-back registers on the same edge it pops.
// Push and pop are only issued by the parent when not full / not empty.
module wb_chan_fifo
  import riscv_uop_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  wb_entry_t push_entry,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t         mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;

  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == '0);
  assign head  = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; flush empties the FIFO at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_r[wr_ptr_r] <= push_entry;
  end

endmodule

// File: rtl/wb_retire_arbiter.sv
// Retire/write-back arbiter: buffers results from NUM_CH execution channels,
// picks one per cycle (round-robin or fixed priority) and drives the single
// register-file write-back port, counting retired instructions.
module wb_retire_arbiter
  import riscv_uop_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DEPTH    = 4,
  parameter int ARB_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    i_valid,
  output logic [NUM_CH-1:0]    o_ready,
  input  logic [NUM_CH*5-1:0]  i_rd,
  input  logic [NUM_CH*32-1:0] i_data,
  input  logic                 i_stall,
  input  logic                 i_flush,
  output logic                 o_retire_valid,
  output logic                 o_wb_en,
  output logic [4:0]           o_wb_rd,
  output logic [31:0]          o_wb_data,
  output logic [31:0]          o_instret
);

  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] full_s;
  logic [NUM_CH-1:0] empty_s;
  logic [NUM_CH-1:0] push_s;
  logic [NUM_CH-1:0] pop_s;
  logic [NUM_CH-1:0] elig_s;
  wb_entry_t         head_s [NUM_CH];
  wb_entry_t         head_sel_s;
  logic              grant_s;
  logic [GW-1:0]     grant_idx_s;

  logic [GW-1:0]     last_grant_r;
  logic              retire_valid_r;
  logic              wb_en_r;
  logic [4:0]        wb_rd_r;
  logic [31:0]       wb_data_r;
  logic [31:0]       instret_r;

  // Ready depends only on FIFO occupancy and flush, never on this cycle's pop.
  assign o_ready = ~full_s & {NUM_CH{~i_flush}};
  assign push_s  = i_valid & o_ready;
  assign elig_s  = ~empty_s & {NUM_CH{~(i_stall | i_flush)}};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    wb_chan_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push_s[c]),
      .pop        (pop_s[c]),
      .flush      (i_flush),
      .push_entry ({i_rd[c*5 +: 5], i_data[c*32 +: 32]}),
      .full       (full_s[c]),
      .empty      (empty_s[c]),
      .head       (head_s[c])
    );
  end

  assign head_sel_s = head_s[grant_idx_s];

  // Winner selection: scan candidates from lowest to highest preference so the
  // most preferred eligible channel is written last and wins.
  always_comb begin
    logic [GW-1:0] cand;
    cand        = '0;
    grant_s     = 1'b0;
    grant_idx_s = '0;
    pop_s       = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ARB_MODE == ARB_FIXED) begin
        cand = GW'(k);
      end else begin
        cand = GW'((int'(last_grant_r) + 1 + k) % NUM_CH);
      end
      if (elig_s[cand]) begin
        grant_s     = 1'b1;
        grant_idx_s = cand;
      end else begin
        grant_s     = grant_s;
        grant_idx_s = grant_idx_s;
      end
    end
    if (grant_s) begin
      pop_s[grant_idx_s] = 1'b1;
    end else begin
      pop_s = '0;
    end
  end

  // Write-back port, arbitration pointer and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r   <= GW'(NUM_CH - 1);
      retire_valid_r <= 1'b0;
      wb_en_r        <= 1'b0;
      wb_rd_r        <= 5'd0;
      wb_data_r      <= 32'd0;
      instret_r      <= 32'd0;
    end else begin
      retire_valid_r <= grant_s;
      wb_en_r        <= grant_s && (head_sel_s.rd != 5'd0);
      if (grant_s) begin
        last_grant_r <= grant_idx_s;
        wb_rd_r      <= head_sel_s.rd;
        wb_data_r    <= head_sel_s.data;
        instret_r    <= instret_r + 32'd1;
      end
    end
  end

  assign o_retire_valid = retire_valid_r;
  assign o_wb_en        = wb_en_r;
  assign o_wb_rd        = wb_rd_r;
  assign o_wb_data      = wb_data_r;
  assign o_instret      = instret_r;

endmodule

// File: tb/tb_wb_retire_arbiter.sv
// Self-checking bench for wb_retire_arbiter. Instance A (3 channels,
// round-robin) is checked against a queue-based reference model; instance B
// (2 channels, fixed priority) is checked with directed expectations.
module tb_wb_retire_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NUM_CH=3, DEPTH=4, round-robin
  logic [2:0]  a_valid = '0;
  logic [2:0]  a_ready;
  logic [14:0] a_rd = '0;
  logic [95:0] a_data = '0;
  logic        a_stall = 1'b0, a_flush = 1'b0;
  logic        a_rv, a_en;
  logic [4:0]  a_wb_rd;
  logic [31:0] a_wb_data, a_instret;

  // Instance B: NUM_CH=2, DEPTH=4, fixed priority
  logic [1:0]  b_valid = '0;
  logic [1:0]  b_ready;
  logic [9:0]  b_rd = '0;
  logic [63:0] b_data = '0;
  logic        b_stall = 1'b0, b_flush = 1'b0;
  logic        b_rv, b_en;
  logic [4:0]  b_wb_rd;
  logic [31:0] b_wb_data, b_instret;

  wb_retire_arbiter #(.NUM_CH(3), .DEPTH(4), .ARB_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .i_valid(a_valid), .o_ready(a_ready),
    .i_rd(a_rd), .i_data(a_data), .i_stall(a_stall), .i_flush(a_flush),
    .o_retire_valid(a_rv), .o_wb_en(a_en), .o_wb_rd(a_wb_rd),
    .o_wb_data(a_wb_data), .o_instret(a_instret)
  );

  wb_retire_arbiter #(.NUM_CH(2), .DEPTH(4), .ARB_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .i_valid(b_valid), .o_ready(b_ready),
    .i_rd(b_rd), .i_data(b_data), .i_stall(b_stall), .i_flush(b_flush),
    .o_retire_valid(b_rv), .o_wb_en(b_en), .o_wb_rd(b_wb_rd),
    .o_wb_data(b_wb_data), .o_instret(b_instret)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model for instance A: one queue per channel of {rd, data}.
  logic [36:0] mq [3][$];
  int          m_last;
  logic        m_rv, m_en;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_instret;
  logic [2:0]  e_ready_pre, o_ready_pre;
  logic [73:0] obs_v, exp_v;

  task automatic do_reset();
    a_valid = '0; a_stall = 1'b0; a_flush = 1'b0;
    b_valid = '0; b_stall = 1'b0; b_flush = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) mq[c].delete();
    m_last = 2; m_rv = 1'b0; m_en = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_instret = 32'd0;
  endtask

  // Advance instance A by one clock and step the model; leaves observed and
  // predicted packets in obs_v / exp_v for the caller to compare.
  task automatic clk_a();
    int g;
    logic [36:0] ent;
    #1;
    g = -1;
    o_ready_pre = a_ready;
    for (int c = 0; c < 3; c++) e_ready_pre[c] = (mq[c].size() < 4) && !a_flush;
    if (!a_stall && !a_flush) begin
      for (int k = 1; k <= 3; k++) begin
        if (g < 0 && mq[(m_last + k) % 3].size() > 0) g = (m_last + k) % 3;
      end
    end
    m_rv = 1'b0; m_en = 1'b0;
    if (g >= 0) begin
      ent = mq[g].pop_front();
      m_rv = 1'b1; m_rd = ent[36:32]; m_data = ent[31:0];
      m_en = (m_rd != 5'd0); m_instret = m_instret + 32'd1; m_last = g;
    end
    for (int c = 0; c < 3; c++) begin
      if (a_valid[c] && e_ready_pre[c]) mq[c].push_back({a_rd[c*5 +: 5], a_data[c*32 +: 32]});
    end
    if (a_flush) for (int c = 0; c < 3; c++) mq[c].delete();
    @(posedge clk); #1;
    obs_v = {a_rv, a_en, a_wb_rd, a_wb_data, a_instret, o_ready_pre};
    exp_v = {m_rv, m_en, m_rd, m_data, m_instret, e_ready_pre};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_vec++;
    if ({a_ready, a_rv, a_en, a_wb_rd, a_wb_data, a_instret} !== {3'b111, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL reset_a: got rdy=%b rv=%b en=%b rd=%0d data=%h instret=%h, expected rdy=111 and zeros",
               a_ready, a_rv, a_en, a_wb_rd, a_wb_data, a_instret);
    end
    n_vec++;
    if ({b_ready, b_rv, b_en, b_wb_rd, b_wb_data, b_instret} !== {2'b11, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL reset_b: got rdy=%b rv=%b en=%b rd=%0d data=%h instret=%h, expected rdy=11 and zeros",
               b_ready, b_rv, b_en, b_wb_rd, b_wb_data, b_instret);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    a_valid = 3'b001; a_rd = 15'd5; a_data = {64'd0, 32'hDEADBEEF};
    for (int i = 0; i < 3; i++) begin
      clk_a();
      a_valid = '0;
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL single_cyc%0d: got %h, expected %h", i, obs_v, exp_v);
      end
      if (i == 1) begin
        n_vec++;
        if ({a_rv, a_en, a_wb_rd, a_wb_data, a_instret} !== {1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'd1}) begin
          n_err++;
          $display("FAIL single_wb: got rv=%b en=%b rd=%0d data=%h instret=%0d, expected 1 1 5 deadbeef 1",
                   a_rv, a_en, a_wb_rd, a_wb_data, a_instret);
        end
      end
    end
  endtask

  task automatic test_rr_fairness();
    do_reset();
    a_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_valid = 3'b111;
      for (int c = 0; c < 3; c++) begin
        a_rd[c*5 +: 5]    = 5'(c + 1);
        a_data[c*32 +: 32] = 32'(c * 16 + i);
      end
      clk_a();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL rr_fill%0d: got %h, expected %h", i, obs_v, exp_v);
      end
    end
    a_valid = '0; a_stall = 1'b0;
    for (int j = 0; j < 12; j++) begin
      clk_a();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL rr_model%0d: got %h, expected %h", j, obs_v, exp_v);
      end
      n_vec++;
      if ({a_rv, a_wb_data} !== {1'b1, 32'((j % 3) * 16 + j / 3)}) begin
        n_err++;
        $display("FAIL rr_order%0d: got rv=%b data=%h, expected rv=1 data=%h",
                 j, a_rv, a_wb_data, 32'((j % 3) * 16 + j / 3));
      end
    end
  endtask

  task automatic test_fixed_priority();
    logic [31:0] exp_d [4];
    logic [4:0]  exp_r [4];
    exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hB0; exp_d[3] = 32'hB1;
    exp_r[0] = 5'd1;   exp_r[1] = 5'd1;   exp_r[2] = 5'd2;   exp_r[3] = 5'd2;
    do_reset();
    b_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      b_valid = 2'b11;
      b_rd    = {5'd2, 5'd1};
      b_data  = {32'(32'hB0 + i), 32'(32'hA0 + i)};
      @(posedge clk); #1;
    end
    b_valid = '0; b_stall = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({b_rv, b_en, b_wb_rd, b_wb_data} !== {1'b1, 1'b1, exp_r[j], exp_d[j]}) begin
        n_err++;
        $display("FAIL fixed_order%0d: got rv=%b en=%b rd=%0d data=%h, expected 1 1 %0d %h",
                 j, b_rv, b_en, b_wb_rd, b_wb_data, exp_r[j], exp_d[j]);
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if ({b_rv, b_instret} !== {1'b0, 32'd4}) begin
      n_err++;
      $display("FAIL fixed_done: got rv=%b instret=%0d, expected rv=0 instret=4", b_rv, b_instret);
    end
  endtask

  task automatic test_backpressure();
    int cnt;
    do_reset();
    a_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_valid = 3'b010;
      a_rd    = {5'd0, 5'(7 + i), 5'd0};
      a_data  = {32'd0, 32'(32'h100 + i), 32'd0};
      clk_a();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL bp_fill%0d: got %h, expected %h", i, obs_v, exp_v);
      end
    end
    n_vec++;
    if (o_ready_pre[1] !== 1'b0) begin
      n_err++;
      $display("FAIL bp_ready: got o_ready[1]=%b during 5th push, expected 0", o_ready_pre[1]);
    end
    a_valid = '0; a_stall = 1'b0;
    cnt = 0;
    for (int j = 0; j < 6; j++) begin
      clk_a();
      if (a_rv === 1'b1) cnt++;
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL bp_drain%0d: got %h, expected %h", j, obs_v, exp_v);
      end
    end
    n_vec++;
    if (cnt !== 4) begin
      n_err++;
      $display("FAIL bp_count: got %0d retires, expected 4", cnt);
    end
  endtask

  task automatic test_x0_wrap();
    do_reset();
    force dut_a.instret_r = 32'hFFFF_FFFF;
    #1;
    release dut_a.instret_r;
    m_instret = 32'hFFFF_FFFF;
    a_valid = 3'b100; a_rd = {5'd0, 10'd0}; a_data = {32'h0000_0055, 64'd0};
    for (int i = 0; i < 2; i++) begin
      clk_a();
      a_valid = '0;
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL x0_cyc%0d: got %h, expected %h", i, obs_v, exp_v);
      end
    end
    n_vec++;
    if ({a_rv, a_en, a_instret} !== {1'b1, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL x0_wrap: got rv=%b en=%b instret=%h, expected 1 0 00000000", a_rv, a_en, a_instret);
    end
  endtask

  task automatic test_flush();
    do_reset();
    a_valid = 3'b001; a_rd = 15'd3; a_data = 96'h11;
    for (int i = 0; i < 2; i++) begin
      clk_a();
      a_valid = '0;
    end
    a_stall = 1'b1; a_valid = 3'b111; a_rd = {5'd4, 5'd5, 5'd6}; a_data = {32'h21, 32'h22, 32'h23};
    clk_a();
    n_vec++;
    if (obs_v !== exp_v) begin
      n_err++;
      $display("FAIL flush_fill: got %h, expected %h", obs_v, exp_v);
    end
    a_stall = 1'b0; a_flush = 1'b1; a_valid = 3'b001; a_data = {64'd0, 32'h99};
    for (int i = 0; i < 3; i++) begin
      clk_a();
      a_flush = 1'b0; a_valid = '0;
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL flush_cyc%0d: got %h, expected %h", i, obs_v, exp_v);
      end
    end
    n_vec++;
    if ({a_rv, a_en, a_ready, a_instret} !== {1'b0, 1'b0, 3'b111, 32'd1}) begin
      n_err++;
      $display("FAIL flush_state: got rv=%b en=%b rdy=%b instret=%0d, expected 0 0 111 1",
               a_rv, a_en, a_ready, a_instret);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      a_valid = 3'($urandom_range(0, 7));
      a_rd    = 15'($urandom);
      a_data  = {$urandom, $urandom, $urandom};
      a_stall = ($urandom_range(0, 4) == 0);
      a_flush = ($urandom_range(0, 29) == 0);
      clk_a();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL random%0d: got %h, expected %h", i, obs_v, exp_v);
      end
    end
    a_valid = '0; a_stall = 1'b0; a_flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_fairness();
    test_fixed_priority();
    test_backpressure();
    test_x0_wrap();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
